weight_loader: RTL and testbench
================================

# weight_loader

Write-side companion to `weight_mem`: accepts a stream of weights over a valid/ready handshake and drives the memory's write port (`w_en`, `w_add`, `w_in`) for one neuron of one layer. An instance sits beside each neuron's weight memory and fills it before inference. It counts exactly `num_weight` words, checks framing via `in_last`, and reports completion or error.

## Interface
- `num_weight`, 3: weights per neuron; must be ≤ 2^`address_width`.
- `neuron_no`, 5: neuron index this loader answers to.
- `layer_no`, 1: layer index this loader answers to.
- `address_width`, 10: weight memory address width.
- `data_width`, 16: weight word width.

- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a load; sampled only in IDLE.
- `cfg_layer` in 8: target layer, sampled with `start`.
- `cfg_neuron` in 8: target neuron, sampled with `start`.
- `abort` in 1: return to IDLE from any state.
- `in_valid` in 1: stream word valid.
- `in_ready` out 1: loader accepts a word.
- `in_data` in `data_width`: weight (or checksum) word.
- `in_last` in 1: marks the final word of the frame.
- `w_en` out 1: memory write enable.
- `w_add` out `address_width`: memory write address.
- `w_in` out `data_width`: memory write data.
- `busy` out 1: high in LOAD.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: framing/checksum error; sticky until next accepted `start` or reset.

## Operation
- States: IDLE, LOAD, DONE, ERR.
- IDLE: `in_ready`=0. `start`=1 with `cfg_layer`==`layer_no` and `cfg_neuron`==`neuron_no` → LOAD, counter cleared, `err` cleared. Mismatched IDs: `start` ignored, stay IDLE.
- LOAD: `in_ready`=1. Handshake = `in_valid`&&`in_ready`. Each weight handshake registers `w_in`=`in_data`, `w_add`=counter, `w_en`=1; counter += 1.
- Without checksum: handshake at counter == `num_weight`-1 with `in_last`=1 → DONE; with `in_last`=0 → ERR. `in_last`=1 at counter < `num_weight`-1 → word is still written, then ERR.
- DONE: `done`=1 for one cycle, then IDLE.
- ERR: `err`=1, `in_ready`=0; `start` behaves as in IDLE (matching `start` → LOAD, clears `err`).
- `abort` (any state, priority over all else except reset): → IDLE next cycle, no write that cycle, `err` unchanged, counter cleared.
- `start` while in LOAD: ignored.
- Counter width `address_width`; it never wraps because the frame ends at `num_weight`.
- Memory already written before ERR/abort is not rolled back.

## Timing
- Reset (`rst_n`=0 at edge): state IDLE; `in_ready`, `w_en`, `busy`, `done`, `err` = 0; `w_add`, `w_in`, counter, checksum = 0.
- `start` accepted at edge N → `in_ready`=1, `busy`=1 from cycle N+1.
- Handshake at edge M → `w_en`=1 with `w_add`/`w_in` valid during cycle M+1; `w_en` low otherwise (one write per handshake, back-to-back allowed at full rate).
- Final handshake at edge M → `done` (or `err`) high in cycle M+1, coincident with the last `w_en`; `in_ready`=0 in cycle M+1.
- Reset mid-load: immediate return to reset values; no write in the following cycle.

## Configuration
- `WEIGHT_LOADER_CHECKSUM_EN` defined: frame is `num_weight` weights plus one trailing checksum word. Loader keeps the sum of weights modulo 2^`data_width`. The checksum word is not written to memory. `in_last` is required on it, and never on a weight; any other `in_last` placement → ERR. Checksum ≠ sum → ERR; equal → DONE.
- Not defined: no checksum logic; frame is exactly `num_weight` weights with `in_last` on the last.

## Test plan
- Default params, `start` with layer 1/neuron 5, stream 0x0011, 0x0022, 0x0033 (last on third), `in_valid` held high → writes addr 0/1/2 in three consecutive cycles; `done` pulse coincident with the addr-2 write; `err`=0.
- `start` with neuron 4 → stays IDLE, `in_ready`=0, no `w_en`.
- `in_last` on the second word → addr 0 and 1 written, `err`=1 sticky; a later matching `start` clears it.
- `in_valid` toggling 1/0 and `abort` after the first word → one write only, back to IDLE, `in_ready`=0.
- `rst_n` low mid-frame → all outputs 0 next cycle; a new full frame then loads cleanly.
- With `WEIGHT_LOADER_CHECKSUM_EN`: weights 0x8000, 0x8000, 0x0001, checksum 0x0001 → DONE. Same weights with checksum 0x0002 → ERR; three writes occur either way.

Source files
------------

// File: rtl/weight_loader.sv
// Streams one neuron's weights into its weight memory: one registered write per handshake, done/err one cycle after the final word.
// in_ready is high only in LOAD. Define WEIGHT_LOADER_CHECKSUM_EN to require a trailing checksum word (sum of weights, not written).
module weight_loader #(
  parameter int num_weight    = 3,
  parameter int neuron_no     = 5,
  parameter int layer_no      = 1,
  parameter int address_width = 10,
  parameter int data_width    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [7:0]               cfg_layer,
  input  logic [7:0]               cfg_neuron,
  input  logic                     abort,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [data_width-1:0]    in_data,
  input  logic                     in_last,
  output logic                     w_en,
  output logic [address_width-1:0] w_add,
  output logic [data_width-1:0]    w_in,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  localparam logic [address_width-1:0] LAST_IDX = address_width'(num_weight - 1);

  state_t                   state_q;
  logic [address_width-1:0] cnt_q, cnt_d;
  logic [address_width-1:0] w_add_q;
  logic [data_width-1:0]    w_in_q;
  logic                     in_ready_q, w_en_q, busy_q, done_q, err_q;
  logic                     id_match, hs;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [data_width-1:0]    sum_q, sum_d;
  logic                     ck_q;  // all weights taken; next word is the checksum
`endif

  assign id_match = start && (cfg_layer == 8'(layer_no)) && (cfg_neuron == 8'(neuron_no));
  assign hs       = in_valid && in_ready_q;
  assign cnt_d    = cnt_q + address_width'(1);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  assign sum_d    = sum_q + in_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      w_add_q    <= '0;
      w_in_q     <= '0;
      in_ready_q <= 1'b0;
      w_en_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      ck_q       <= 1'b0;
`endif
    end else begin
      w_en_q <= 1'b0;
      done_q <= 1'b0;
      if (abort) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        in_ready_q <= 1'b0;
        busy_q     <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        ck_q       <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE, ERR: begin
            if (id_match) begin
              state_q    <= LOAD;
              cnt_q      <= '0;
              err_q      <= 1'b0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
              sum_q      <= '0;
              ck_q       <= 1'b0;
`endif
            end
          end
          LOAD: begin
            if (hs) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
              if (ck_q) begin
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                ck_q       <= 1'b0;
                if (in_last && (in_data == sum_q)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
                end
              end else begin
                w_en_q  <= 1'b1;
                w_add_q <= cnt_q;
                w_in_q  <= in_data;
                cnt_q   <= cnt_d;
                sum_q   <= sum_d;
                if (in_last) begin
                  state_q    <= ERR;
                  err_q      <= 1'b1;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b0;
                end else if (cnt_q == LAST_IDX) begin
                  ck_q <= 1'b1;
                end
              end
`else
              w_en_q  <= 1'b1;
              w_add_q <= cnt_q;
              w_in_q  <= in_data;
              cnt_q   <= cnt_d;
              if (in_last || (cnt_q == LAST_IDX)) begin
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                if (in_last && (cnt_q == LAST_IDX)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
                end
              end
`endif
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_ready = in_ready_q;
  assign w_en     = w_en_q;
  assign w_add    = w_add_q;
  assign w_in     = w_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: expected writes/outcomes come from a frame-level model; a negedge monitor pops and compares.
module tb_weight_loader;
  localparam int NW = 3;
  localparam int AW = 10;
  localparam int DW = 16;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam int CKW = 1;
`else
  localparam int CKW = 0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic          in_valid = 1'b0, in_last = 1'b0;
  logic [7:0]    cfg_layer = 8'd0, cfg_neuron = 8'd0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, w_en, busy, done, err;
  logic [AW-1:0] w_add;
  logic [DW-1:0] w_in;

  weight_loader #(.num_weight(NW), .neuron_no(5), .layer_no(1), .address_width(AW), .data_width(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .w_en(w_en), .w_add(w_add), .w_in(w_in), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct packed { bit is_done; bit with_wr; } out_t;

  wr_t           exp_wr[$];
  out_t          exp_out[$];
  int            wr_cyc[$];
  logic [DW-1:0] fr_dat[$];
  bit            fr_lst[$];
  int            cyc = 0, total = 0, bad = 0;
  logic          err_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: every write and every done/err event is matched against the scoreboard.
  always @(negedge clk) begin
    wr_t  e;
    out_t o;
    cyc++;
    if (w_en) begin
      wr_cyc.push_back(cyc);
      if (exp_wr.size() == 0) fail_now("unexpected_write");
      else begin
        e = exp_wr.pop_front();
        chk("w_add", int'(w_add), int'(e.a));
        chk("w_in", int'(w_in), int'(e.d));
      end
    end
    if (done || (err && !err_prev)) begin
      if (exp_out.size() == 0) fail_now("unexpected_done_or_err");
      else begin
        o = exp_out.pop_front();
        chk("outcome_done", int'(done), int'(o.is_done));
        chk("outcome_err", int'(err), int'(!o.is_done));
        chk("outcome_with_write", int'(w_en), int'(o.with_wr));
      end
    end
    err_prev = err;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_load(input logic [7:0] l, input logic [7:0] n);
    bit m;
    m = (l == 8'd1) && (n == 8'd5);
    idle(2);
    start = 1'b1; cfg_layer = l; cfg_neuron = n;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_ready", int'(in_ready), int'(m));
    chk("start_busy", int'(busy), int'(m));
    if (m) chk("start_err_clear", int'(err), 0);
  endtask

  task automatic drive_word(input logic [DW-1:0] d, input bit l);
    int  n;
    bit  rdy;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    do begin
      rdy = in_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 50);
    if (!rdy) fail_now("handshake_timeout");
  endtask

  // Frame-level reference: which words land in memory and how the frame ends.
  task automatic expect_frame(output int n_use);
    int   sum;
    out_t o;
    sum = 0;
    n_use = 0;
    for (int i = 0; i < fr_dat.size(); i++) begin
      n_use = i + 1;
      if (i < NW) begin
        exp_wr.push_back({AW'(i), fr_dat[i]});
        sum = (sum + int'(fr_dat[i])) % (1 << DW);
      end
      if (CKW == 0) begin
        if (fr_lst[i] || i == NW - 1) begin
          o.is_done = fr_lst[i] && (i == NW - 1); o.with_wr = 1'b1;
          exp_out.push_back(o);
          return;
        end
      end else if (i < NW) begin
        if (fr_lst[i]) begin
          o.is_done = 1'b0; o.with_wr = 1'b1;
          exp_out.push_back(o);
          return;
        end
      end else begin
        o.is_done = fr_lst[i] && (int'(fr_dat[i]) == sum); o.with_wr = 1'b0;
        exp_out.push_back(o);
        return;
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_out.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail_now("drain_timeout");
  endtask

  task automatic send_frame(input bit full_rate);
    int n;
    expect_frame(n);
    for (int i = 0; i < n; i++) begin
      drive_word(fr_dat[i], fr_lst[i]);
      if (!full_rate && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        idle($urandom_range(1, 2));
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_drain();
  endtask

  task automatic set_good(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    fr_dat.delete(); fr_lst.delete();
    fr_dat.push_back(a); fr_dat.push_back(b); fr_dat.push_back(c);
    fr_lst.push_back(1'b0); fr_lst.push_back(1'b0); fr_lst.push_back(CKW == 0);
    if (CKW == 1) begin
      fr_dat.push_back(a + b + c);
      fr_lst.push_back(1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int            len, lp;
    logic [DW-1:0] s;

    // Reset state
    idle(3);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_w_en", int'(w_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_w_add", int'(w_add), 0);
    chk("rst_w_in", int'(w_in), 0);
    rst_n = 1'b1;

    // Basic frame at full rate: three back-to-back writes
    wr_cyc.delete();
    start_load(8'd1, 8'd5);
    set_good(16'h0011, 16'h0022, 16'h0033);
    send_frame(1'b1);
    chk("b2b_write_count", wr_cyc.size(), 3);
    if (wr_cyc.size() == 3) chk("b2b_write_span", wr_cyc[2] - wr_cyc[0], 2);
    chk("basic_err", int'(err), 0);

    // Mismatched neuron: ignored
    start_load(8'd1, 8'd4);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("mismatch_in_ready", int'(in_ready), 0);
    end

    // Early in_last: two writes, sticky err, cleared by next matching start
    start_load(8'd1, 8'd5);
    fr_dat.delete(); fr_lst.delete();
    fr_dat.push_back(16'h0101); fr_dat.push_back(16'h0202); fr_dat.push_back(16'h0303);
    fr_lst.push_back(1'b0); fr_lst.push_back(1'b1); fr_lst.push_back(1'b0);
    send_frame(1'b0);
    idle(3);
    chk("err_sticky", int'(err), 1);
    chk("err_in_ready", int'(in_ready), 0);
    start_load(8'd1, 8'd5);
    abort = 1'b1; @(negedge clk); abort = 1'b0;

    // Toggling valid then abort after first word
    start_load(8'd1, 8'd5);
    in_valid = 1'b0; idle(1);
    exp_wr.push_back({AW'(0), 16'h0AAA});
    drive_word(16'h0AAA, 1'b0);
    in_valid = 1'b0;
    idle(1);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_busy", int'(busy), 0);
    idle(2);
    chk("abort_err", int'(err), 0);
    chk("abort_pending_writes", exp_wr.size(), 0);

    // Reset mid-frame, then a clean frame
    start_load(8'd1, 8'd5);
    exp_wr.push_back({AW'(0), 16'h0BBB});
    drive_word(16'h0BBB, 1'b0);
    in_data = 16'h0CCC;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_w_en", int'(w_en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_w_add", int'(w_add), 0);
    chk("midrst_w_in", int'(w_in), 0);
    rst_n = 1'b1; in_valid = 1'b0;
    start_load(8'd1, 8'd5);
    set_good(16'h1234, 16'h5678, 16'h9ABC);
    send_frame(1'b1);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    // Checksum wraps modulo 2^16
    start_load(8'd1, 8'd5);
    fr_dat.delete(); fr_lst.delete();
    fr_dat.push_back(16'h8000); fr_dat.push_back(16'h8000); fr_dat.push_back(16'h0001); fr_dat.push_back(16'h0001);
    fr_lst.push_back(1'b0); fr_lst.push_back(1'b0); fr_lst.push_back(1'b0); fr_lst.push_back(1'b1);
    send_frame(1'b1);
    start_load(8'd1, 8'd5);
    fr_dat[3] = 16'h0002;
    send_frame(1'b1);
    chk("ck_bad_err", int'(err), 1);
`endif

    // Randomized frames
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        start_load(8'($urandom_range(0, 3)), 8'($urandom_range(6, 255)));
        continue;
      end
      start_load(8'd1, 8'd5);
      fr_dat.delete(); fr_lst.delete();
      len = NW + CKW;
      lp  = ($urandom_range(0, 1) == 1) ? len - 1 : $urandom_range(0, len);
      for (int i = 0; i < len; i++) begin
        fr_dat.push_back(DW'($urandom));
        fr_lst.push_back(i == lp);
      end
      if (CKW == 1 && $urandom_range(0, 1) == 1) begin
        s = '0;
        for (int i = 0; i < NW; i++) s = s + fr_dat[i];
        fr_dat[len-1] = s;
      end
      send_frame($urandom_range(0, 1) == 1);
    end

    idle(4);
    chk("left_writes", exp_wr.size(), 0);
    chk("left_outcomes", exp_out.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
